// File: rtl/bcd_pkg.sv
// Shared definitions for the shared binary-to-BCD conversion engine.
// Contents: FSM state type, default configuration, per-digit add-3
// correction and the elaboration-time digit-count check.
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEF_BIN_W  = 9;
    localparam int unsigned DEF_DIGITS = 3;
    localparam int unsigned DEF_NREQ   = 2;

    // True when DIGITS decimal digits can hold every BIN_W-bit value.
    function automatic bit digits_ok(input int unsigned digits, input int unsigned bin_w);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p > ((64'd1 << bin_w) - 64'd1);
    endfunction

    localparam bit DEF_CFG_OK = digits_ok(DEF_DIGITS, DEF_BIN_W);

    // Only 5..9 are corrected, so the 4-bit add cannot overflow.
    function automatic logic [3:0] digit_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bundle of the shared BCD converter.
// master: requesters + result consumer (drive req_valid, req_bin, rsp_ready).
// slave : the converter (drives req_ready, rsp_valid, rsp_id, rsp_bcd, busy).
interface bcd_conv_arbiter_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned BIN_W  = 9,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*BIN_W-1:0] req_bin;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [4*DIGITS-1:0]   rsp_bcd;
    logic                  rsp_ready;
    logic                  busy;

    modport master (
        output req_valid, req_bin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_bcd, busy
    );

    modport slave (
        input  req_valid, req_bin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_bcd, busy
    );
endinterface

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration.
// Ports: bcd_in  - DIGITS packed BCD digits before the iteration
//        bit_in  - next operand bit (MSB first)
//        bcd_out - digits after add-3 correction and a 1-bit left shift
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                bit_in,
    output logic [4*DIGITS-1:0] bcd_out
);
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = digit_adj(bcd_in[4*k +: 4]);
        end
        // Top bit falls off; the digit-count check keeps it zero.
        bcd_out = (4*DIGITS)'({adj, bit_in});
    end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter in front of one iterative binary-to-BCD engine.
// Ports: clk, rst (synchronous, active high)
//        bus (slave): per-requester valid/ready/operand, one response
//        channel (rsp_valid/rsp_ready, rsp_id, rsp_bcd) and busy.
// A conversion takes BIN_W clocks from the accept edge to rsp_valid.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = DEF_BIN_W,
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic               clk,
    input logic               rst,
    bcd_conv_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    if (!digits_ok(DIGITS, BIN_W)) begin : g_bad_digits
        $error("bcd_conv_arbiter: DIGITS too small for BIN_W");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("bcd_conv_arbiter: NREQ must be 2..8");
    end

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [4*DIGITS-1:0] rsp_bcd_q, rsp_bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;

    logic                gnt_found;
    logic [ID_W-1:0]     gnt_idx;
    logic [BIN_W-1:0]    gnt_bin;
    logic [NREQ-1:0]     req_ready_c;
    logic [4*DIGITS-1:0] step_out;

    bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
        .bcd_in (bcd_q),
        .bit_in (bin_q[BIN_W-1]),
        .bcd_out(step_out)
    );

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_bin   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr_q) + i) % NREQ;
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
                gnt_bin   = bus.req_bin[cand*BIN_W +: BIN_W];
            end
        end
    end

    always_comb begin
        req_ready_c = '0;
        if (!rst && state_q == S_IDLE && gnt_found) begin
            req_ready_c[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        rsp_bcd_d   = rsp_bcd_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    bin_d    = gnt_bin;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    rsp_id_d = gnt_idx;
                    ptr_d    = ID_W'((32'(gnt_idx) + 1) % NREQ);
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d = step_out;
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    // Result goes to its own register so it survives the next accept.
                    rsp_bcd_d   = step_out;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            rsp_bcd_q   <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            rsp_bcd_q   <= rsp_bcd_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_bcd   = rsp_bcd_q;
    assign bus.busy      = busy_q;
endmodule
